slv_i2c_reg_ctrl: RTL

Register-bank controller that sequences transactions for the I2C slave FSM. It decides ACK/NACK for the address, register-pointer and data bytes, and maintains an auto-incrementing register pointer. It supplies transmit bytes for reads. It also arbitrates the internal register bank between I2C writes and a local host write port. It sits beside the slave FSM: its outputs drive the FSM's I_ACK and transmit-data inputs.

---
 rtl/slv_i2c_pkg.sv | 17 +
 rtl/slv_i2c_reg_ctrl_if.sv | 48 ++++
 rtl/slv_i2c_regbank.sv | 47 ++++
 rtl/slv_i2c_reg_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/slv_i2c_pkg.sv
// Shared definitions for the I2C slave register controller: FSM states,
// bus-level ACK/NACK levels and the default slave address.
package slv_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REG_PTR = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_IGNORE  = 3'd4
  } state_t;

  localparam logic       ACK_BIT      = 1'b0;
  localparam logic       NACK_BIT     = 1'b1;
  localparam logic [6:0] DEF_SLV_ADDR = 7'h3C;

endpackage

// File: rtl/slv_i2c_reg_ctrl_if.sv
// Signal bundle between the slave FSM / local host (master side) and the
// register controller (slave side).
interface slv_i2c_reg_ctrl_if #(
  parameter int DATA_SZ  = 8,
  parameter int NUM_REGS = 16
);
  localparam int AW = $clog2(NUM_REGS);

  logic               I_ADDR_VLD;
  logic [DATA_SZ-2:0] I_ADDR_SLV;
  logic               I_RW;
  logic               I_REG_VLD;
  logic [DATA_SZ-1:0] I_ADDR_REG;
  logic               I_DATA_VLD;
  logic [DATA_SZ-1:0] I_DATA_RD;
  logic               I_TX_REQ;
  logic               I_MACK_VLD;
  logic               I_ACK_MSTR;
  logic               I_STOP;
  logic               I_HOST_WE;
  logic [AW-1:0]      I_HOST_ADDR;
  logic [DATA_SZ-1:0] I_HOST_WDATA;

  logic               O_ACK;
  logic [DATA_SZ-1:0] O_DATA_TX;
  logic [DATA_SZ-1:0] O_HOST_RDATA;
  logic               O_HOST_COLL;
  logic               O_WR_STB;
  logic [AW-1:0]      O_WR_ADDR;
  logic [DATA_SZ-1:0] O_WR_DATA;
  logic               O_BUSY;

  modport master (
    output I_ADDR_VLD, I_ADDR_SLV, I_RW, I_REG_VLD, I_ADDR_REG, I_DATA_VLD,
           I_DATA_RD, I_TX_REQ, I_MACK_VLD, I_ACK_MSTR, I_STOP, I_HOST_WE,
           I_HOST_ADDR, I_HOST_WDATA,
    input  O_ACK, O_DATA_TX, O_HOST_RDATA, O_HOST_COLL, O_WR_STB, O_WR_ADDR,
           O_WR_DATA, O_BUSY
  );

  modport slave (
    input  I_ADDR_VLD, I_ADDR_SLV, I_RW, I_REG_VLD, I_ADDR_REG, I_DATA_VLD,
           I_DATA_RD, I_TX_REQ, I_MACK_VLD, I_ACK_MSTR, I_STOP, I_HOST_WE,
           I_HOST_ADDR, I_HOST_WDATA,
    output O_ACK, O_DATA_TX, O_HOST_RDATA, O_HOST_COLL, O_WR_STB, O_WR_ADDR,
           O_WR_DATA, O_BUSY
  );
endinterface

// File: rtl/slv_i2c_regbank.sv
// Register bank with an I2C write port that wins over the host write port,
// plus registered transmit and host read ports (old data on read-during-write).
module slv_i2c_regbank #(
  parameter int DATA_SZ  = 8,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               i2c_we,
  input  logic [AW-1:0]      i2c_addr,
  input  logic [DATA_SZ-1:0] i2c_wdata,
  input  logic               host_we,
  input  logic [AW-1:0]      host_addr,
  input  logic [DATA_SZ-1:0] host_wdata,
  input  logic               tx_re,
  input  logic [AW-1:0]      tx_addr,
  output logic [DATA_SZ-1:0] tx_rdata,
  output logic [DATA_SZ-1:0] host_rdata,
  output logic               host_coll
);

  logic [DATA_SZ-1:0] mem [NUM_REGS];
  logic               host_hit;

  assign host_hit = i2c_we && host_we && (i2c_addr == host_addr);

  // NOTE: the bank must read back zero after reset, so it is built from
  // resettable flops and cannot map onto a RAM macro.
  // NOTE: all state here uses non-blocking assignments so every read port
  // sees the value from before this edge's writes.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      tx_rdata   <= '0;
      host_rdata <= '0;
      host_coll  <= 1'b0;
    end else begin
      if (host_we && !host_hit) mem[host_addr] <= host_wdata;
      if (i2c_we)               mem[i2c_addr]  <= i2c_wdata;
      if (tx_re)                tx_rdata       <= mem[tx_addr];
      host_rdata <= mem[host_addr];
      host_coll  <= host_hit;
    end
  end

endmodule

// File: rtl/slv_i2c_reg_ctrl.sv
// Transaction sequencer beside the I2C slave FSM: ACK/NACK decisions,
// auto-incrementing register pointer and register-bank access.
module slv_i2c_reg_ctrl
  import slv_i2c_pkg::*;
#(
  parameter int                  DATA_SZ  = 8,
  parameter logic [DATA_SZ-2:0]  SLV_ADDR = DEF_SLV_ADDR,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input logic               CLK,
  input logic               RST_n,
  slv_i2c_reg_ctrl_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);

  state_t             state, state_next;
  logic [AW-1:0]      ptr, ptr_next, ptr_inc;
  logic               ack, ack_next;
  logic               wr_en, tx_re;
  logic               wr_stb;
  logic [AW-1:0]      wr_addr;
  logic [DATA_SZ-1:0] wr_data;
  logic               addr_match, reg_ok;
  logic [DATA_SZ-1:0] tx_rdata, host_rdata;
  logic               host_coll;

  assign ptr_inc    = ptr + AW'(1);
  assign addr_match = (bus.I_ADDR_SLV == SLV_ADDR);
  assign reg_ok     = int'(bus.I_ADDR_REG) < NUM_REGS;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ack_next   = ack;
    ptr_next   = ptr;
    wr_en      = 1'b0;
    tx_re      = 1'b0;
    if (bus.I_STOP) begin
      state_next = ST_IDLE;
      ack_next   = 1'b0;
    end else if (bus.I_ADDR_VLD) begin
      ack_next   = addr_match;
      state_next = !addr_match ? ST_IGNORE : (bus.I_RW ? ST_READ : ST_REG_PTR);
    end else begin
      unique case (state)
        ST_REG_PTR: if (bus.I_REG_VLD) begin
          ack_next   = reg_ok;
          state_next = reg_ok ? ST_WRITE : ST_IGNORE;
          if (reg_ok) ptr_next = bus.I_ADDR_REG[AW-1:0];
        end
        ST_WRITE: if (bus.I_DATA_VLD) begin
          // Read-only registers are NACKed but still advance the pointer.
          wr_en    = !RO_MASK[ptr];
          ack_next = !RO_MASK[ptr];
          ptr_next = ptr_inc;
        end
        ST_READ: begin
          tx_re = bus.I_TX_REQ;
          if (bus.I_TX_REQ) ptr_next = ptr_inc;
          if (bus.I_MACK_VLD) begin
            case (bus.I_ACK_MSTR)
              NACK_BIT: begin
                state_next = ST_IGNORE;
                ack_next   = 1'b0;
              end
              ACK_BIT: state_next = ST_READ;
              default: state_next = ST_READ;
            endcase
          end
        end
        ST_IGNORE: ack_next = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      ack     <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      ack    <= ack_next;
      wr_stb <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr;
        wr_data <= bus.I_DATA_RD;
      end
    end
  end

  slv_i2c_regbank #(.DATA_SZ(DATA_SZ), .NUM_REGS(NUM_REGS), .AW(AW)) u_bank (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .i2c_we     (wr_en),
    .i2c_addr   (ptr),
    .i2c_wdata  (bus.I_DATA_RD),
    .host_we    (bus.I_HOST_WE),
    .host_addr  (bus.I_HOST_ADDR),
    .host_wdata (bus.I_HOST_WDATA),
    .tx_re      (tx_re),
    .tx_addr    (ptr),
    .tx_rdata   (tx_rdata),
    .host_rdata (host_rdata),
    .host_coll  (host_coll)
  );

  assign bus.O_ACK        = ack;
  assign bus.O_DATA_TX    = tx_rdata;
  assign bus.O_HOST_RDATA = host_rdata;
  assign bus.O_HOST_COLL  = host_coll;
  assign bus.O_WR_STB     = wr_stb;
  assign bus.O_WR_ADDR    = wr_addr;
  assign bus.O_WR_DATA    = wr_data;
  assign bus.O_BUSY       = (state != ST_IDLE);

endmodule
